pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MDU_MAX_CYC, default 34: MDU cycle limit before timeout, range 2..255.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 load_use_i  input  1  load-use stall request from hazard_unit (its stallH_o).
REQ-005 branch_tkn_i  input  1  branch/jump taken, resolved in EX.
REQ-006 mdu_op_i  input  1  EX holds a multi-cycle mul/div op.
REQ-007 mdu_done_i  input  1  MDU result valid this cycle.
REQ-008 dmem_req_i  input  1  MEM stage has an outstanding data-memory access.
REQ-009 dmem_ack_i  input  1  data memory completes the access this cycle.
REQ-010 pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o  output  1 each  per-stage register enables.
REQ-011 if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  output  1 each  insert bubble into that register.
REQ-012 mdu_start_o  output  1  one-cycle start pulse to MDU.
REQ-013 mdu_err_o  output  1  sticky MDU timeout flag.
REQ-014 state_o  output  2  FSM state: RUN=0, MDU_WAIT=1, MEM_WAIT=2.

Function
REQ-015 FSM SHALL have states RUN, MDU_WAIT, MEM_WAIT; encoding 3 unused, SHALL return to RUN next cycle.
REQ-016 mem_stall = dmem_req_i & ~dmem_ack_i; all enables 0 and all flushes 0 while mem_stall=1, in any state.
REQ-017 RUN, mem_stall=1 -> MEM_WAIT; MEM_WAIT stays until dmem_ack_i=1; enables reassert in the ack cycle (zero added latency), then -> RUN.
REQ-018 RUN, mem_stall=0, mdu_op_i=1 -> mdu_start_o=1 for that cycle only, -> MDU_WAIT; pc/if_id/id_ex enables 0, ex_mem_flush_o=1.
REQ-019 MDU_WAIT: pc/if_id/id_ex enables 0, ex_mem_flush_o=1, 8-bit counter increments per cycle from 1.
REQ-020 MDU_WAIT with mdu_done_i=1: all enables 1, flushes per REQ-022/023, -> RUN; mdu_start_o SHALL NOT re-pulse that cycle.
REQ-021 MDU_WAIT with counter==MDU_MAX_CYC and no done: mdu_err_o set, treat as done (REQ-020); mdu_err_o clears only on reset.
REQ-022 RUN, no mem/MDU stall, branch_tkn_i=1: all enables 1, if_id_flush_o=1, id_ex_flush_o=1; branch SHALL win over load_use_i.
REQ-023 RUN, no other stall, load_use_i=1, branch_tkn_i=0: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, id_ex_en_o=1, ex_mem_en_o=1.
REQ-024 Otherwise all enables 1, all flushes 0.
REQ-025 Priority: mem_stall > MDU > branch > load-use; branch_tkn_i held during a freeze SHALL apply on release cycle only.
REQ-026 A flush output SHALL never be 1 while the same register's enable is 0, except ex_mem_flush_o in MDU stall.
REQ-027 All outputs SHALL be free of combinational paths from flush outputs to inputs other than listed stimuli; no latches.

Reset
REQ-028 Reset SHALL force state RUN, counter 0, mdu_err_o 0, mdu_start_o 0.
REQ-029 During rst_i=1 outputs SHALL be: all enables 0, if_id/id_ex flushes 1, ex_mem_flush_o 1.
REQ-030 Reset mid-MDU_WAIT or mid-MEM_WAIT SHALL abandon the operation; first post-reset cycle is RUN.

Configuration
REQ-031 Macro PIPE_CTRL_PERF_EN defined: adds outputs stall_cnt_o (32) counting cycles with pc_en_o=0, flush_cnt_o (32) counting cycles with if_id_flush_o=1; both reset to 0, wrap at 2^32.
REQ-032 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-033 load_use_i=1 one cycle in RUN -> pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1 same cycle; next cycle all enables 1.
REQ-034 mdu_op_i=1, mdu_done_i after 5 cycles -> mdu_start_o single pulse, state_o=1 for 5 cycles, release on done cycle, mdu_err_o=0.
REQ-035 MDU_MAX_CYC=4, mdu_done_i never -> mdu_err_o=1 after 4 cycles in MDU_WAIT, state_o returns to 0.
REQ-036 dmem_req_i=1 with ack after 3 cycles while branch_tkn_i=1 -> all outputs frozen 3 cycles, flushes asserted only on ack cycle.
REQ-037 rst_i=1 during MDU_WAIT -> next cycle state_o=0, mdu_err_o=0, no mdu_start_o pulse.
REQ-038 PIPE_CTRL_PERF_EN defined, 3 load-use stalls and 2 branches -> stall_cnt_o=3, flush_cnt_o=2.

Source files
------------

// File: rtl/pipeline_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Purpose: central stall/flush controller for a 5-stage in-order pipeline.
//   Arbitrates, highest priority first, between:
//     1. data-memory stall (MEM access outstanding and not acknowledged),
//     2. multi-cycle MDU (mul/div) operation held in EX,
//     3. taken branch/jump resolved in EX,
//     4. load-use hazard reported by the hazard unit.
//   It drives per-stage register enables and bubble (flush) requests, and
//   supervises the MDU with a cycle limit that sets a sticky error flag.
//
// Parameters:
//   MDU_MAX_CYC    MDU cycles allowed before timeout (2..255)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   load_use_i     load-use stall request
//   branch_tkn_i   branch/jump taken (EX)
//   mdu_op_i       EX holds a multi-cycle MDU op
//   mdu_done_i     MDU result valid this cycle
//   dmem_req_i     MEM stage data access outstanding
//   dmem_ack_i     data access completes this cycle
//   pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o      register enables
//   if_id_flush_o, id_ex_flush_o, ex_mem_flush_o       bubble insertion
//   mdu_start_o    one-cycle MDU start pulse
//   mdu_err_o      sticky MDU timeout flag (cleared by reset only)
//   state_o        FSM state: 0 RUN, 1 MDU_WAIT, 2 MEM_WAIT
//
// Optional build macro PIPE_CTRL_PERF_EN adds:
//   stall_cnt_o    cycles with pc_en_o = 0 (32-bit, wrapping)
//   flush_cnt_o    cycles with if_id_flush_o = 1 (32-bit, wrapping)
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int unsigned MDU_MAX_CYC = 34
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_use_i,
  input  logic        branch_tkn_i,
  input  logic        mdu_op_i,
  input  logic        mdu_done_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        ex_mem_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic        mdu_start_o,
  output logic        mdu_err_o,
  output logic [1:0]  state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [7:0] MaxCyc = 8'(MDU_MAX_CYC);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic       mem_stall;
  logic       mdu_release;

  // Outputs for a cycle in which the pipeline is allowed to move:
  // branch beats load-use, load-use holds PC/IF-ID and bubbles ID-EX.
  logic       rel_pc_en;
  logic       rel_if_id_en;
  logic       rel_if_id_flush;
  logic       rel_id_ex_flush;

  assign mem_stall   = dmem_req_i & ~dmem_ack_i;
  assign mdu_release = mdu_done_i | (cnt_q == MaxCyc);

  always_comb begin
    rel_pc_en       = 1'b1;
    rel_if_id_en    = 1'b1;
    rel_if_id_flush = 1'b0;
    rel_id_ex_flush = 1'b0;
    if (branch_tkn_i) begin
      rel_if_id_flush = 1'b1;
      rel_id_ex_flush = 1'b1;
    end else if (load_use_i) begin
      rel_pc_en       = 1'b0;
      rel_if_id_en    = 1'b0;
      rel_id_ex_flush = 1'b1;
    end
  end

  // Next state and outputs. Every branch starts from a fully frozen
  // pipeline (all enables and flushes 0), which is exactly the mem-stall
  // behaviour, so mem_stall only has to suppress the other actions.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    pc_en_o        = 1'b0;
    if_id_en_o     = 1'b0;
    id_ex_en_o     = 1'b0;
    ex_mem_en_o    = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    mdu_start_o    = 1'b0;

    case (state_q)
      // MEM_WAIT releases in the ack cycle with the full RUN decode, so an
      // MDU op or branch sitting behind the memory access is not lost.
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
        end else if (mdu_op_i) begin
          mdu_start_o    = 1'b1;
          ex_mem_flush_o = 1'b1;
          cnt_d          = 8'd1;
          state_d        = MDU_WAIT;
        end else begin
          pc_en_o       = rel_pc_en;
          if_id_en_o    = rel_if_id_en;
          id_ex_en_o    = 1'b1;
          ex_mem_en_o   = 1'b1;
          if_id_flush_o = rel_if_id_flush;
          id_ex_flush_o = rel_id_ex_flush;
          state_d       = RUN;
        end
      end

      // A memory stall during the MDU wait freezes the wait as well:
      // the counter holds and a done/timeout is not acted on until the
      // memory access completes.
      MDU_WAIT: begin
        if (!mem_stall) begin
          if (mdu_release) begin
            pc_en_o       = rel_pc_en;
            if_id_en_o    = rel_if_id_en;
            id_ex_en_o    = 1'b1;
            ex_mem_en_o   = 1'b1;
            if_id_flush_o = rel_if_id_flush;
            id_ex_flush_o = rel_id_ex_flush;
            err_d         = err_q | ~mdu_done_i;
            cnt_d         = '0;
            state_d       = RUN;
          end else begin
            ex_mem_flush_o = 1'b1;
            cnt_d          = cnt_q + 8'd1;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = RUN;
      end
    endcase

    if (rst_i) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      mdu_start_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state_o   = state_q;
  assign mdu_err_o = err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, ~pc_en_o};
    flush_cnt_d = flush_cnt_q + {31'd0, if_id_flush_o};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_ctrl;

  localparam int unsigned MAXC = 6;

  logic       clk_i = 1'b0;
  logic       rst_i, load_use_i, branch_tkn_i, mdu_op_i, mdu_done_i;
  logic       dmem_req_i, dmem_ack_i;
  logic       pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o;
  logic       if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
  logic       mdu_start_o, mdu_err_o;
  logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  pipeline_ctrl #(.MDU_MAX_CYC(MAXC)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .load_use_i     (load_use_i),
    .branch_tkn_i   (branch_tkn_i),
    .mdu_op_i       (mdu_op_i),
    .mdu_done_i     (mdu_done_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ack_i     (dmem_ack_i),
    .pc_en_o        (pc_en_o),
    .if_id_en_o     (if_id_en_o),
    .id_ex_en_o     (id_ex_en_o),
    .ex_mem_en_o    (ex_mem_en_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .ex_mem_flush_o (ex_mem_flush_o),
    .mdu_start_o    (mdu_start_o),
    .mdu_err_o      (mdu_err_o),
    .state_o        (state_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int stepno   = 0;

  // Reference model: what the pipeline is currently waiting for.
  bit          m_busy_mdu;   // an MDU op has been started and not released
  bit          m_wait_mem;   // a memory stall was seen and not yet released
  int unsigned m_elapsed;    // MDU_WAIT cycles so far, 1 on the first one
  bit          m_err;
  int unsigned m_stalls;
  int unsigned m_flushes;

  // Expected output vector:
  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, ex_mem_fl, start}
  localparam logic [7:0] O_RESET  = 8'b0000_1110;
  localparam logic [7:0] O_FREEZE = 8'b0000_0000;
  localparam logic [7:0] O_MDUWT  = 8'b0000_0010;
  localparam logic [7:0] O_START  = 8'b0000_0011;
  localparam logic [7:0] O_BRANCH = 8'b1111_1100;
  localparam logic [7:0] O_LDUSE  = 8'b0011_0100;
  localparam logic [7:0] O_NORMAL = 8'b1111_0000;

  task automatic step(input logic r, input logic lu, input logic br,
                      input logic op, input logic dn, input logic rq,
                      input logic ak);
    logic [7:0] exp_o, got_o;
    logic [1:0] exp_state;
    bit         stall, timeout;
    rst_i = r; load_use_i = lu; branch_tkn_i = br; mdu_op_i = op;
    mdu_done_i = dn; dmem_req_i = rq; dmem_ack_i = ak;
    stepno++;
    #1;
    stall   = rq && !ak;
    timeout = m_busy_mdu && (m_elapsed == MAXC);
    if (r)                                   exp_o = O_RESET;
    else if (stall)                          exp_o = O_FREEZE;
    else if (m_busy_mdu && !(dn || timeout)) exp_o = O_MDUWT;
    else if (!m_busy_mdu && op)              exp_o = O_START;
    else if (br)                             exp_o = O_BRANCH;
    else if (lu)                             exp_o = O_LDUSE;
    else                                     exp_o = O_NORMAL;
    exp_state = m_busy_mdu ? 2'd1 : (m_wait_mem ? 2'd2 : 2'd0);
    got_o = {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mdu_start_o};

    checks++;
    assert (got_o === exp_o) else begin
      failures++;
      $error("FAIL outputs step=%0d observed=%b expected=%b", stepno, got_o, exp_o);
    end
    checks++;
    assert (state_o === exp_state) else begin
      failures++;
      $error("FAIL state step=%0d observed=%0d expected=%0d", stepno, state_o, exp_state);
    end
    checks++;
    assert (mdu_err_o === m_err) else begin
      failures++;
      $error("FAIL mdu_err step=%0d observed=%b expected=%b", stepno, mdu_err_o, m_err);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    assert (stall_cnt_o === 32'(m_stalls)) else begin
      failures++;
      $error("FAIL stall_cnt step=%0d observed=%0d expected=%0d", stepno, stall_cnt_o, m_stalls);
    end
    checks++;
    assert (flush_cnt_o === 32'(m_flushes)) else begin
      failures++;
      $error("FAIL flush_cnt step=%0d observed=%0d expected=%0d", stepno, flush_cnt_o, m_flushes);
    end
`endif

    @(posedge clk_i);
    if (r) begin
      m_busy_mdu = 0; m_wait_mem = 0; m_elapsed = 0; m_err = 0;
      m_stalls = 0;   m_flushes = 0;
    end else begin
      if (!exp_o[7]) m_stalls++;
      if (exp_o[3])  m_flushes++;
      if (stall) begin
        if (!m_busy_mdu) m_wait_mem = 1;
      end else if (m_busy_mdu) begin
        if (dn || timeout) begin
          if (!dn) m_err = 1;
          m_busy_mdu = 0;
          m_elapsed  = 0;
        end else begin
          m_elapsed++;
        end
      end else begin
        m_wait_mem = 0;
        if (op) begin
          m_busy_mdu = 1;
          m_elapsed  = 1;
        end
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1; load_use_i = 0; branch_tkn_i = 0; mdu_op_i = 0;
    mdu_done_i = 0; dmem_req_i = 0; dmem_ack_i = 0;
    m_busy_mdu = 0; m_wait_mem = 0; m_elapsed = 0; m_err = 0;
    m_stalls = 0; m_flushes = 0;
    @(negedge clk_i);

    // reset outputs
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // single load-use stall then free flow
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // MDU op released by done after 5 wait cycles
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // MDU timeout: never done
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < int'(MAXC); i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // memory stall with branch held: frozen 3 cycles, flush on ack cycle
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // branch beats load-use
    step(0, 1, 1, 0, 0, 0, 0);

    // reset during MDU_WAIT abandons the op
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // memory stall in the middle of an MDU wait, branch on release
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // MEM_WAIT released by ack with an MDU op waiting
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1, 0, 0);

    // randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
